// File: rtl/iris_pkg.sv
// Shared types and constants for the iris feature path: feature slot names,
// feature width and the assembler FSM states.
package iris_pkg;

    localparam int FEAT_W   = 5;
    localparam int FEAT_MAX = (1 << FEAT_W) - 1;
    localparam int NUM_FEAT = 4;

    typedef enum logic [1:0] {
        SEPAL_LEN = 2'd0,
        SEPAL_WID = 2'd1,
        PETAL_LEN = 2'd2,
        PETAL_WID = 2'd3
    } feat_idx_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/iris_feat_sat.sv
// Clamps an input byte to the feature range; clip flags any value that was
// above the feature maximum.
module iris_feat_sat #(
    parameter int IN_W   = 8,
    parameter int FEAT_W = 5
) (
    input  logic [IN_W-1:0]   in_data,
    output logic [FEAT_W-1:0] feat,
    output logic              clip
);

    localparam logic [IN_W-1:0] SAT_MAX = IN_W'((1 << FEAT_W) - 1);

    assign clip = (in_data > SAT_MAX);
    assign feat = clip ? SAT_MAX[FEAT_W-1:0] : in_data[FEAT_W-1:0];

endmodule

// File: rtl/iris_feature_assembler.sv
// Assembles framed 4-byte iris samples into saturated features, presents them
// on a held valid/ready output and counts framing errors and delivered frames.
module iris_feature_assembler #(
    parameter int IN_W      = 8,
    parameter int FEAT_W    = 5,
    parameter int ERR_CNT_W = 8,
    parameter int FRM_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FEAT_W-1:0]    sepal_length_cm,
    output logic [FEAT_W-1:0]    sepal_width_cm,
    output logic [FEAT_W-1:0]    petal_length_cm,
    output logic [FEAT_W-1:0]    petal_width_cm,
    output logic                 out_sat,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [FRM_CNT_W-1:0] frame_count
);

    import iris_pkg::*;

    state_e            state;
    logic [1:0]        idx;
    logic [FEAT_W-1:0] stage [NUM_FEAT];
    logic              stage_sat;
    logic [FEAT_W-1:0] feat_q [NUM_FEAT];

    logic [FEAT_W-1:0] feat;
    logic              clip;
    logic              accept;
    logic              load;
    logic              err_ev;

    iris_feat_sat #(
        .IN_W   (IN_W),
        .FEAT_W (FEAT_W)
    ) u_sat (
        .in_data (in_data),
        .feat    (feat),
        .clip    (clip)
    );

    assign accept = in_valid && in_ready;
    assign load   = (state == HOLD) && (!out_valid || out_ready);
    // An orphan byte in IDLE or a restart inside a frame both break framing.
    assign err_ev = accept && (((state == IDLE) && !in_sof) ||
                               ((state == COLLECT) && in_sof));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b0;
            stage_sat <= 1'b0;
            // NOTE: the stage is cleared on reset so a frame cut short by reset can never resurface.
            for (int i = 0; i < NUM_FEAT; i++) stage[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads pre-edge state.
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept && in_sof) begin
                        stage[SEPAL_LEN] <= feat;
                        stage_sat        <= clip;
                        idx              <= 2'd1;
                        state            <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (in_sof) begin
                            stage[SEPAL_LEN] <= feat;
                            stage_sat        <= clip;
                            idx              <= 2'd1;
                        end else begin
                            stage[idx] <= feat;
                            stage_sat  <= stage_sat | clip;
                            idx        <= idx + 2'd1;
                            if (idx == 2'(PETAL_WID)) begin
                                state    <= HOLD;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (load) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        idx       <= '0;
                        stage_sat <= 1'b0;
                        for (int i = 0; i < NUM_FEAT; i++) stage[i] <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Output slot: load from the stage, otherwise drop valid after a handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_sat     <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
            frame_count <= '0;
            for (int i = 0; i < NUM_FEAT; i++) feat_q[i] <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_sat   <= stage_sat;
                for (int i = 0; i < NUM_FEAT; i++) feat_q[i] <= stage[i];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) frame_count <= frame_count + FRM_CNT_W'(1);

            frame_err <= err_ev;
            if (err_ev && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
        end
    end

    assign sepal_length_cm = feat_q[SEPAL_LEN];
    assign sepal_width_cm  = feat_q[SEPAL_WID];
    assign petal_length_cm = feat_q[PETAL_LEN];
    assign petal_width_cm  = feat_q[PETAL_WID];

endmodule

// File: tb/tb_iris_feature_assembler.sv
// Scoreboard bench for iris_feature_assembler: a byte-level framing model
// predicts samples and error counts; a negedge monitor checks every handoff.
module tb_iris_feature_assembler;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  sepal_length_cm;
    logic [4:0]  sepal_width_cm;
    logic [4:0]  petal_length_cm;
    logic [4:0]  petal_width_cm;
    logic        out_sat;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [15:0] frame_count;

    iris_feature_assembler dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_sof          (in_sof),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sepal_length_cm (sepal_length_cm),
        .sepal_width_cm  (sepal_width_cm),
        .petal_length_cm (petal_length_cm),
        .petal_width_cm  (petal_width_cm),
        .out_sat         (out_sat),
        .frame_err       (frame_err),
        .err_count       (err_count),
        .frame_count     (frame_count)
    );

    typedef struct packed {
        logic       sat;
        logic [4:0] f3;
        logic [4:0] f2;
        logic [4:0] f1;
        logic [4:0] f0;
    } sample_t;

    int         n_checks = 0;
    int         n_err    = 0;
    sample_t    exp_q[$];
    logic [7:0] partial[$];
    int         exp_errs  = 0;
    int         pulse_cnt = 0;
    int         delivered = 0;
    logic       ready_val = 1'b1;
    logic       rand_en   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sample_t cur_out();
        sample_t s;
        s.sat = out_sat;
        s.f0  = sepal_length_cm;
        s.f1  = sepal_width_cm;
        s.f2  = petal_length_cm;
        s.f3  = petal_width_cm;
        return s;
    endfunction

    function automatic logic [4:0] clamp(input logic [7:0] b);
        return (b > 8'd31) ? 5'd31 : b[4:0];
    endfunction

    // Framing model: a frame is a sof byte followed by three non-sof bytes.
    task automatic model_byte(input logic [7:0] b, input logic sof);
        sample_t s;
        if (sof) begin
            if (partial.size() != 0) exp_errs++;
            partial.delete();
            partial.push_back(b);
        end else if (partial.size() == 0) begin
            exp_errs++;
        end else begin
            partial.push_back(b);
            if (partial.size() == 4) begin
                s.f0  = clamp(partial[0]);
                s.f1  = clamp(partial[1]);
                s.f2  = clamp(partial[2]);
                s.f3  = clamp(partial[3]);
                s.sat = (partial[0] > 8'd31) || (partial[1] > 8'd31) ||
                        (partial[2] > 8'd31) || (partial[3] > 8'd31);
                exp_q.push_back(s);
                partial.delete();
            end
        end
    endtask

    // Holds the byte until accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic sof);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            model_byte(b, sof);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        send_byte(b3, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!((exp_q.size() == 0) && !out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'((exp_q.size() == 0) && !out_valid), 32'd1);
    endtask

    task automatic check_errs(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_err_count"}, 32'(err_count), 32'((exp_errs > 255) ? 255 : exp_errs));
        check({tag, "_err_pulses"}, 32'(pulse_cnt), 32'(exp_errs));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_features", 32'(cur_out()), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        partial.delete();
        exp_q.delete();
        exp_errs  = 0;
        pulse_cnt = 0;
        delivered = 0;
        repeat (2) @(posedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Single writer of out_ready: either the requested level or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Monitor: scoreboard pops on every handoff, hold checks while stalled.
    initial begin
        logic    prev_stall = 1'b0;
        sample_t held;
        sample_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (frame_err) pulse_cnt++;
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(cur_out()), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_sample", 32'(cur_out()), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample_features", 32'(cur_out()), 32'(e));
                    end
                    check("frame_count_at_handoff", 32'(frame_count), 32'(delivered % 65536));
                    delivered++;
                end
                prev_stall = out_valid && !out_ready;
                held       = cur_out();
            end
        end
    end

    initial begin
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sof   = 1'b0;
        #1;
        do_reset();

        // Reset mid-COLLECT with an error recorded and a byte pending.
        send_byte(8'h11, 1'b0);
        send_byte(8'd12, 1'b1);
        send_byte(8'd13, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'd14;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Clean frame with latency check.
        ready_val = 1'b1;
        send_frame(8'd5, 8'd3, 8'd4, 8'd2);
        @(negedge clk);
        check("latency_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("clean_frame_count", 32'(frame_count), 32'd1);
        wait_drain();

        // Saturation.
        send_frame(8'd40, 8'd31, 8'd200, 8'd7);
        wait_drain();

        // Backpressure: one sample held on the output, the next parked in HOLD.
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        send_frame(8'd33, 8'd6, 8'd7, 8'd8);
        repeat (3) @(negedge clk);
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        @(negedge clk);
        #1;
        check("bp_b2b_valid_0", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        check("bp_b2b_valid_1", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("bp_frame_count", 32'(frame_count), 32'(delivered));
        wait_drain();

        // Framing: orphan byte in IDLE, then a restarted frame.
        send_byte(8'd77, 1'b0);
        @(negedge clk);
        check("orphan_pulse_hi", 32'(frame_err), 32'd1);
        @(negedge clk);
        check("orphan_pulse_lo", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        check_errs("orphan");
        send_byte(8'd6, 1'b1);
        send_frame(8'd9, 8'd1, 8'd2, 8'd3);
        check_errs("restart");
        wait_drain();

        // Randomized frames with injected framing faults and random out_ready.
        rand_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int kind = int'($urandom_range(0, 9));
            logic [7:0] b [4];
            for (int i = 0; i < 4; i++)
                b[i] = $urandom_range(0, 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
            if (kind == 0) begin
                send_byte(8'($urandom_range(0, 255)), 1'b0);
            end else if (kind == 1) begin
                int k = int'($urandom_range(0, 2));
                send_byte(8'($urandom_range(0, 255)), 1'b1);
                for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
            end
            send_frame(b[0], b[1], b[2], b[3]);
        end
        rand_en   = 1'b0;
        ready_val = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wait_drain();
        check_errs("random");

        // Error counter saturation with 300 back-to-back orphans.
        for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        check_errs("err_sat");
        check("err_sat_value", 32'(err_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
